// File: rtl/axil_reg_file_if.sv
// AXI4-Lite bus bundle shared by the CSR master and the register file.
interface AXIL_IF #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport Slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_file.sv
// AXI4-Lite CSR endpoint: NUM_REGS x 32-bit registers, read/write or read-only per RO_MASK.
//
// state  | meaning
// W_IDLE | collecting AW/W (either may be held), commit when both present
// W_RESP | write response pending on B
// R_IDLE | ready for AR
// R_RESP | read data pending on R
module axil_reg_file #(
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter int                  ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  AXIL_IF.Slave                    s_axil,
  output logic [NUM_REGS*32-1:0]   reg_out,
  input  logic [NUM_REGS*32-1:0]   reg_in,
  output logic [NUM_REGS-1:0]      wr_pulse,
  output logic [NUM_REGS-1:0]      rd_pulse
);
  localparam int                  IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0]          RESP_OKAY   = 2'd0;
  localparam logic [1:0]          RESP_SLVERR = 2'd2;
  localparam logic [1:0]          RESP_DECERR = 2'd3;
  localparam logic [NUM_REGS-1:0] PULSE_ONE   = {{(NUM_REGS-1){1'b0}}, 1'b1};

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [31:0]           reg_q    [NUM_REGS];
  logic [31:0]           reg_in_a [NUM_REGS];

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;

  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;
  logic [NUM_REGS-1:0]   wr_pulse_q, rd_pulse_q;

  logic                  awready_int, wready_int, arready_int;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] w_addr_cur;
  logic [31:0]           w_data_cur;
  logic [3:0]            w_strb_cur;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  w_oor, r_oor;
  logic [1:0]            w_resp;

  // Readies come only from registered state, never from the valids.
  assign awready_int = !aw_held && (w_state == W_IDLE);
  assign wready_int  = !w_held  && (w_state == W_IDLE);
  assign arready_int = (r_state == R_IDLE);

  assign s_axil.awready = awready_int;
  assign s_axil.wready  = wready_int;
  assign s_axil.bvalid  = (w_state == W_RESP);
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_int;
  assign s_axil.rvalid  = (r_state == R_RESP);
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;

  logic unused_prot;
  assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[32*i +: 32] = reg_q[i];
      reg_in_a[i]         = reg_in[32*i +: 32];
    end
  end

  always_comb begin
    aw_hs      = s_axil.awvalid && awready_int;
    w_hs       = s_axil.wvalid  && wready_int;
    ar_hs      = s_axil.arvalid && arready_int;
    commit     = (aw_hs || aw_held) && (w_hs || w_held);

    w_addr_cur = aw_held ? aw_addr_q : s_axil.awaddr;
    w_data_cur = w_held  ? w_data_q  : s_axil.wdata;
    w_strb_cur = w_held  ? w_strb_q  : s_axil.wstrb;

    w_idx      = w_addr_cur[IDX_W+1:2];
    w_oor      = (w_addr_cur >> (IDX_W + 2)) != '0;
    r_idx      = s_axil.araddr[IDX_W+1:2];
    r_oor      = (s_axil.araddr >> (IDX_W + 2)) != '0;

    if (w_oor)               w_resp = RESP_DECERR;
    else if (RO_MASK[w_idx]) w_resp = RESP_SLVERR;
    else                     w_resp = RESP_OKAY;

    w_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (s_axil.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase

    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (s_axil.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state    <= W_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      w_state    <= w_next;
      wr_pulse_q <= '0;
      if (aw_hs && !commit) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axil.awaddr;
      end
      if (w_hs && !commit) begin
        w_held   <= 1'b1;
        w_data_q <= s_axil.wdata;
        w_strb_q <= s_axil.wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= w_resp;
        if (w_resp == RESP_OKAY) begin
          wr_pulse_q <= PULSE_ONE << w_idx;
          for (int b = 0; b < 4; b++)
            if (w_strb_cur[b]) reg_q[w_idx][8*b +: 8] <= w_data_cur[8*b +: 8];
        end
      end
    end
  end

  // Read samples reg_q before any same-edge commit lands, so it sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_pulse_q <= '0;
    end else begin
      r_state    <= r_next;
      rd_pulse_q <= '0;
      if (ar_hs) begin
        if (r_oor) begin
          rresp_q <= RESP_DECERR;
          rdata_q <= '0;
        end else begin
          rresp_q    <= RESP_OKAY;
          rdata_q    <= RO_MASK[r_idx] ? reg_in_a[r_idx] : reg_q[r_idx];
          rd_pulse_q <= PULSE_ONE << r_idx;
        end
      end
    end
  end
endmodule
